if_id_skid: RTL and testbench

Parametrised successor of the IF/ID pipeline register. Carries PC, instruction and a sideband field from fetch to decode through a valid/ready handshake. Uses a 2-entry skid buffer so in_ready never depends combinationally on out_ready. Adds synchronous flush for branch/jump redirect and NOP bubble insertion when empty.

---
 rtl/if_id_skid.sv | 156 +++++++++++++++
 tb/tb_if_id_skid.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// -----------------------------------------------------------------------------
// if_id_skid
//
// IF/ID pipeline stage with a two-entry skid buffer. Carries PC, instruction
// and a sideband field from fetch to decode over a valid/ready handshake.
// in_ready is decoded from the registered state only, so there is no
// combinational path from out_ready (or in_valid) to in_ready. A synchronous
// flush empties the stage for branch/jump redirects. While the stage holds
// nothing, out_inst presents NOP_INST so decode sees a harmless bubble.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low (0 = reset)
//   flush      synchronous flush: drops held entries and this cycle's offer
//   in_valid   fetch offers an entry
//   in_ready   stage can accept an entry (state != FULL)
//   in_pc      fetch PC            [ADDR_W]
//   in_inst    fetched instruction [INST_W]
//   in_side    sideband            [SIDE_W]
//   out_valid  head entry valid (state != EMPTY)
//   out_ready  decode accepts the head entry
//   out_pc     PC of head entry
//   out_inst   instruction of head entry, NOP_INST when empty
//   out_side   sideband of head entry
//   occupancy  entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module if_id_skid #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 SIDE_W   = 1,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [SIDE_W-1:0] out_side,
    output logic [1:0]        occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;

    // Main register is the head entry and drives the outputs.
    logic [ADDR_W-1:0]   main_pc_q,   main_pc_d;
    logic [INST_W-1:0]   main_inst_q, main_inst_d;
    logic [SIDE_W-1:0]   main_side_q, main_side_d;

    // Skid register holds the younger entry while decode stalls.
    logic [ADDR_W-1:0]   skid_pc_q,   skid_pc_d;
    logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
    logic [SIDE_W-1:0]   skid_side_q, skid_side_d;

    logic                fire_in;
    logic                fire_out;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;

    assign fire_in   = in_valid  & in_ready;
    assign fire_out  = out_valid & out_ready;

    assign out_pc    = main_pc_q;
    assign out_side  = main_side_q;
    assign out_inst  = out_valid ? main_inst_q : NOP_INST;

    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        main_side_d = main_side_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        skid_side_d = skid_side_q;

        if (flush) begin
            // Redirect: everything held and anything offered is dropped.
            // A fire_out this cycle has still been taken by decode.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (fire_in) begin
                        main_pc_d   = in_pc;
                        main_inst_d = in_inst;
                        main_side_d = in_side;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (fire_in && fire_out) begin
                        // Pass-through: head leaves, new entry becomes head.
                        main_pc_d   = in_pc;
                        main_inst_d = in_inst;
                        main_side_d = in_side;
                    end else if (fire_in) begin
                        // Decode stalled: park the younger entry in the skid.
                        skid_pc_d   = in_pc;
                        skid_inst_d = in_inst;
                        skid_side_d = in_side;
                        state_d     = ST_FULL;
                    end else if (fire_out) begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (fire_out) begin
                        main_pc_d   = skid_pc_q;
                        main_inst_d = skid_inst_q;
                        main_side_d = skid_side_q;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_pc_q   <= '0;
            main_inst_q <= '0;
            main_side_q <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_side_q <= '0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
            main_side_q <= main_side_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_side_q <= skid_side_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
// -----------------------------------------------------------------------------
// tb_if_id_skid
//
// Drives two instances of if_id_skid from the same handshake controls: one at
// default widths and one at ADDR_W=64, INST_W=16, SIDE_W=3, NOP_INST=16'h0001.
// The wide instance sees a PC whose upper half is a scrambled copy of the low
// half, so lost upper bits show up. Expected outputs come from a directed
// vector table, hand-written sequences, and a FIFO-queue reference model used
// for the randomized phase.
// -----------------------------------------------------------------------------
module tb_if_id_skid;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] pc32;
    logic [31:0] inst32;
    logic [2:0]  side3;
    logic [63:0] pc64;

    assign pc64 = {pc32 ^ 32'hDEAD_BEEF, pc32};

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_pc, a_out_inst;
    logic [0:0]  a_out_side;
    logic [1:0]  a_occ;

    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_pc;
    logic [15:0] b_out_inst;
    logic [2:0]  b_out_side;
    logic [1:0]  b_occ;

    if_id_skid dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_pc     (pc32),
        .in_inst   (inst32),
        .in_side   (side3[0:0]),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_pc    (a_out_pc),
        .out_inst  (a_out_inst),
        .out_side  (a_out_side),
        .occupancy (a_occ)
    );

    if_id_skid #(
        .ADDR_W   (64),
        .INST_W   (16),
        .SIDE_W   (3),
        .NOP_INST (16'h0001)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_pc     (pc64),
        .in_inst   (inst32[15:0]),
        .in_side   (side3),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_pc    (b_out_pc),
        .out_inst  (b_out_inst),
        .out_side  (b_out_side),
        .occupancy (b_occ)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the stage is a FIFO of at most two entries.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [2:0]  mq_side[$];

    function automatic logic [63:0] wide_pc(logic [31:0] p);
        return {p ^ 32'hDEAD_BEEF, p};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // e_pc is the 64-bit PC expected from the wide instance; the narrow one
    // must show its low 32 bits.
    task automatic expect_state(string tag, bit e_ir, bit e_ov, logic [1:0] e_occ,
                                logic [63:0] e_pc, logic [31:0] e_inst,
                                logic [2:0] e_side, bit chk_data);
        chk({tag, " a.in_ready"},  64'(a_in_ready),  64'(e_ir));
        chk({tag, " b.in_ready"},  64'(b_in_ready),  64'(e_ir));
        chk({tag, " a.out_valid"}, 64'(a_out_valid), 64'(e_ov));
        chk({tag, " b.out_valid"}, 64'(b_out_valid), 64'(e_ov));
        chk({tag, " a.occupancy"}, 64'(a_occ),       64'(e_occ));
        chk({tag, " b.occupancy"}, 64'(b_occ),       64'(e_occ));
        chk({tag, " a.out_inst"},  64'(a_out_inst),  e_ov ? 64'(e_inst)       : 64'h13);
        chk({tag, " b.out_inst"},  64'(b_out_inst),  e_ov ? 64'(e_inst[15:0]) : 64'h1);
        if (chk_data) begin
            chk({tag, " a.out_pc"},   64'(a_out_pc),   64'(e_pc[31:0]));
            chk({tag, " b.out_pc"},   b_out_pc,        e_pc);
            chk({tag, " a.out_side"}, 64'(a_out_side), 64'(e_side[0]));
            chk({tag, " b.out_side"}, 64'(b_out_side), 64'(e_side));
        end
    endtask

    task automatic check_model(string tag);
        int          n;
        logic [63:0] hp;
        logic [31:0] hi;
        logic [2:0]  hs;
        n  = mq_pc.size();
        hp = (n > 0) ? wide_pc(mq_pc[0]) : 64'h0;
        hi = (n > 0) ? mq_inst[0] : 32'h0;
        hs = (n > 0) ? mq_side[0] : 3'h0;
        expect_state(tag, n < 2, n > 0, 2'(n), hp, hi, hs, n > 0);
    endtask

    // One clock: decide handshakes from the model before the edge, then
    // apply them to the model after it. Returns on the following negedge.
    task automatic cycle();
        bit fin, fout;
        fin  = in_valid && (mq_pc.size() < 2);
        fout = (mq_pc.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            mq_pc.delete();
            mq_inst.delete();
            mq_side.delete();
        end else begin
            if (fout) begin
                void'(mq_pc.pop_front());
                void'(mq_inst.pop_front());
                void'(mq_side.pop_front());
            end
            if (fin) begin
                mq_pc.push_back(pc32);
                mq_inst.push_back(inst32);
                mq_side.push_back(side3);
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          fl;
        bit          iv;
        logic [31:0] pc;
        logic [31:0] inst;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        logic [1:0]  e_occ;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl[NVEC];

    initial begin
        // Directed vectors: inputs applied this cycle, outputs expected this
        // cycle (before the edge that consumes the inputs).
        //          fl iv  pc      inst    or  ir ov occ  e_pc    e_inst
        tbl[0]  = '{0, 1, 32'h00, 32'hA0, 1,  1, 0, 2'd0, 32'h00, 32'h00};
        tbl[1]  = '{0, 1, 32'h04, 32'hA1, 1,  1, 1, 2'd1, 32'h00, 32'hA0};
        tbl[2]  = '{0, 1, 32'h08, 32'hA2, 1,  1, 1, 2'd1, 32'h04, 32'hA1};
        tbl[3]  = '{0, 0, 32'h00, 32'h00, 1,  1, 1, 2'd1, 32'h08, 32'hA2};
        tbl[4]  = '{0, 1, 32'h10, 32'hB0, 0,  1, 0, 2'd0, 32'h00, 32'h00};
        tbl[5]  = '{0, 1, 32'h14, 32'hB1, 0,  1, 1, 2'd1, 32'h10, 32'hB0};
        tbl[6]  = '{0, 0, 32'h00, 32'h00, 0,  0, 1, 2'd2, 32'h10, 32'hB0};
        tbl[7]  = '{0, 0, 32'h00, 32'h00, 1,  0, 1, 2'd2, 32'h10, 32'hB0};
        tbl[8]  = '{0, 0, 32'h00, 32'h00, 1,  1, 1, 2'd1, 32'h14, 32'hB1};
        tbl[9]  = '{0, 1, 32'h20, 32'hC0, 0,  1, 0, 2'd0, 32'h00, 32'h00};
        tbl[10] = '{0, 1, 32'h24, 32'hC1, 0,  1, 1, 2'd1, 32'h20, 32'hC0};
        tbl[11] = '{1, 1, 32'h18, 32'hC2, 0,  0, 1, 2'd2, 32'h20, 32'hC0};
        tbl[12] = '{0, 1, 32'h30, 32'hD0, 0,  1, 0, 2'd0, 32'h00, 32'h00};
        tbl[13] = '{1, 1, 32'h34, 32'hD1, 1,  1, 1, 2'd1, 32'h30, 32'hD0};
        tbl[14] = '{0, 0, 32'h00, 32'h00, 1,  1, 0, 2'd0, 32'h00, 32'h00};
        tbl[15] = '{1, 1, 32'h38, 32'hE5, 1,  1, 0, 2'd0, 32'h00, 32'h00};
        tbl[16] = '{0, 0, 32'h00, 32'h00, 1,  1, 0, 2'd0, 32'h00, 32'h00};

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pc32      = 32'h0;
        inst32    = 32'h0;
        side3     = 3'h0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        expect_state("reset", 1'b1, 1'b0, 2'd0, 64'h0, 32'h0, 3'h0, 1'b1);
        rst = 1'b1;

        // Directed table: streaming, backpressure, flush cases.
        for (int v = 0; v < NVEC; v++) begin
            flush     = tbl[v].fl;
            in_valid  = tbl[v].iv;
            pc32      = tbl[v].pc;
            inst32    = tbl[v].inst;
            side3     = tbl[v].inst[2:0];
            out_ready = tbl[v].ordy;
            #1;
            expect_state($sformatf("vec%0d", v), tbl[v].e_ir, tbl[v].e_ov, tbl[v].e_occ,
                         wide_pc(tbl[v].e_pc), tbl[v].e_inst, tbl[v].e_inst[2:0],
                         tbl[v].e_ov);
            $display("vec %0d fl=%0b iv=%0b pc=%h or=%0b | ov=%0b occ=%0d out_pc=%h out_inst=%h",
                     v, flush, in_valid, pc32, out_ready, a_out_valid, a_occ,
                     a_out_pc, a_out_inst);
            cycle();
        end
        flush = 1'b0;

        // Sixteen back-to-back entries with decode always ready.
        for (int k = 0; k < 18; k++) begin
            in_valid  = (k < 16);
            out_ready = 1'b1;
            pc32      = 32'h100 + 32'(4 * k);
            inst32    = $urandom;
            side3     = 3'($urandom);
            #1;
            check_model($sformatf("stream%0d", k));
            if (k >= 1 && k <= 16) begin
                chk($sformatf("stream%0d head_pc", k), 64'(a_out_pc), 64'(32'h100 + 32'(4 * (k - 1))));
            end
            $display("stream %0d in_pc=%h | ov=%0b occ=%0d out_pc=%h",
                     k, pc32, a_out_valid, a_occ, a_out_pc);
            cycle();
        end

        // Fill to FULL, then assert reset between clock edges.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        pc32      = 32'h200;
        inst32    = 32'h1234_5671;
        side3     = 3'h5;
        cycle();
        pc32      = 32'h204;
        inst32    = 32'h1234_5672;
        side3     = 3'h6;
        cycle();
        in_valid  = 1'b0;
        #1;
        check_model("prefill");
        #1;
        rst = 1'b0;
        #1;
        expect_state("async_rst", 1'b1, 1'b0, 2'd0, 64'h0, 32'h0, 3'h0, 1'b1);
        $display("async reset at %0t | ov=%0b occ=%0d out_pc=%h out_inst=%h",
                 $time, a_out_valid, a_occ, a_out_pc, a_out_inst);
        mq_pc.delete();
        mq_inst.delete();
        mq_side.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_state("post_rst", 1'b1, 1'b0, 2'd0, 64'h0, 32'h0, 3'h0, 1'b1);
        @(negedge clk);

        // Randomized traffic against the FIFO model. Fetch keeps an offer
        // stable until it is taken or flushed.
        begin
            bit hold_offer;
            int accepted;
            hold_offer = 1'b0;
            accepted   = 0;
            for (int c = 0; c < 600; c++) begin
                flush = ($urandom_range(0, 19) == 0);
                if (!hold_offer) begin
                    in_valid = ($urandom_range(0, 9) < 7);
                    pc32     = $urandom;
                    inst32   = $urandom;
                    side3    = 3'($urandom);
                end
                out_ready = ($urandom_range(0, 9) < 6);
                #1;
                check_model($sformatf("rand%0d", c));
                if (in_valid && mq_pc.size() < 2 && !flush) accepted++;
                hold_offer = in_valid && (mq_pc.size() >= 2) && !flush;
                cycle();
            end
            flush    = 1'b0;
            in_valid = 1'b0;
            $display("random phase: %0d entries accepted", accepted);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
